// File: rtl/policy_pkg.sv
// Shared defaults, LFSR constants and FSM state encoding for policy_sel.
package policy_pkg;

    localparam int unsigned Q_WIDTH_DEF     = 8;
    localparam int unsigned N_ACTIONS_DEF   = 9;
    localparam int unsigned IDX_WIDTH_DEF   = 4;
    localparam int unsigned STATE_WIDTH_DEF = 18;

    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/policy_sel_if.sv
// Request/response and Q-table read-port bundle around policy_sel.
interface policy_sel_if
    import policy_pkg::*;
#(
    parameter int unsigned Q_WIDTH     = Q_WIDTH_DEF,
    parameter int unsigned N_ACTIONS   = N_ACTIONS_DEF,
    parameter int unsigned IDX_WIDTH   = IDX_WIDTH_DEF,
    parameter int unsigned STATE_WIDTH = STATE_WIDTH_DEF
);
    logic                   req_valid;
    logic                   req_ready;
    logic [STATE_WIDTH-1:0] req_state;
    logic [N_ACTIONS-1:0]   req_legal;
    logic                   req_explore;
    logic [7:0]             epsilon;

    logic                   q_rd_en;
    logic [STATE_WIDTH-1:0] q_rd_state;
    logic [IDX_WIDTH-1:0]   q_rd_action;
    logic [Q_WIDTH-1:0]     q_rd_data;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDX_WIDTH-1:0]   rsp_action;
    logic [Q_WIDTH-1:0]     rsp_q;
    logic                   rsp_none;
    logic                   rsp_explored;

    // environment side: game controller plus Q-table RAM
    modport master (
        output req_valid, req_state, req_legal, req_explore, epsilon,
        output q_rd_data, rsp_ready,
        input  req_ready, q_rd_en, q_rd_state, q_rd_action,
        input  rsp_valid, rsp_action, rsp_q, rsp_none, rsp_explored
    );

    // policy_sel side
    modport slave (
        input  req_valid, req_state, req_legal, req_explore, epsilon,
        input  q_rd_data, rsp_ready,
        output req_ready, q_rd_en, q_rd_state, q_rd_action,
        output rsp_valid, rsp_action, rsp_q, rsp_none, rsp_explored
    );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reseeded by reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);
    logic [15:0] value_q;
    logic [15:0] value_d;

    // shift right, fold taps in when the bit shifted out is 1
    always_comb begin
        value_d = value_q >> 1;
        if (value_q[0]) begin
            value_d = (value_q >> 1) ^ TAPS;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/policy_sel.sv
// Sequential epsilon-greedy action selector scanning one Q-table row.
module policy_sel
    import policy_pkg::*;
#(
    parameter int unsigned Q_WIDTH     = Q_WIDTH_DEF,
    parameter int unsigned N_ACTIONS   = N_ACTIONS_DEF,
    parameter int unsigned IDX_WIDTH   = IDX_WIDTH_DEF,
    parameter int unsigned STATE_WIDTH = STATE_WIDTH_DEF,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic         clk,
    input  logic         rst,
    policy_sel_if.slave  bus
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_ACTIONS - 1);

    logic [15:0] lfsr;

    lfsr16 #(.SEED(LFSR_SEED), .TAPS(LFSR_TAPS)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    state_e                 state_q,        state_d;
    logic                   req_ready_q,    req_ready_d;
    logic                   rsp_valid_q,    rsp_valid_d;
    logic [IDX_WIDTH-1:0]   rsp_action_q,   rsp_action_d;
    logic [Q_WIDTH-1:0]     rsp_q_q,        rsp_q_d;
    logic                   rsp_none_q,     rsp_none_d;
    logic                   rsp_explored_q, rsp_explored_d;
    logic                   q_rd_en_q,      q_rd_en_d;
    logic [STATE_WIDTH-1:0] q_rd_state_q,   q_rd_state_d;
    logic [IDX_WIDTH-1:0]   q_rd_action_q,  q_rd_action_d;
    logic [N_ACTIONS-1:0]   legal_q,        legal_d;
    logic                   explore_hit_q,  explore_hit_d;
    logic [IDX_WIDTH-1:0]   start_q,        start_d;
    logic                   issuing_q,      issuing_d;
    logic                   eval_valid_q,   eval_valid_d;
    logic                   eval_legal_q,   eval_legal_d;
    logic [IDX_WIDTH-1:0]   eval_idx_q,     eval_idx_d;
    logic                   best_found_q,   best_found_d;
    logic [IDX_WIDTH-1:0]   best_idx_q,     best_idx_d;
    logic [Q_WIDTH-1:0]     best_val_q,     best_val_d;
    logic [IDX_WIDTH-1:0]   fst_idx_q,      fst_idx_d;
    logic [Q_WIDTH-1:0]     fst_val_q,      fst_val_d;
    logic                   exp_found_q,    exp_found_d;
    logic [IDX_WIDTH-1:0]   exp_idx_q,      exp_idx_d;
    logic [Q_WIDTH-1:0]     exp_val_q,      exp_val_d;
    logic [IDX_WIDTH-1:0]   next_idx;

    assign next_idx = IDX_WIDTH'(q_rd_action_q + 1'b1);

    // next-state: accept, issue/evaluate pipeline, response hold
    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_action_d   = rsp_action_q;
        rsp_q_d        = rsp_q_q;
        rsp_none_d     = rsp_none_q;
        rsp_explored_d = rsp_explored_q;
        q_rd_en_d      = q_rd_en_q;
        q_rd_state_d   = q_rd_state_q;
        q_rd_action_d  = q_rd_action_q;
        legal_d        = legal_q;
        explore_hit_d  = explore_hit_q;
        start_d        = start_q;
        issuing_d      = issuing_q;
        eval_valid_d   = eval_valid_q;
        eval_legal_d   = eval_legal_q;
        eval_idx_d     = eval_idx_q;
        best_found_d   = best_found_q;
        best_idx_d     = best_idx_q;
        best_val_d     = best_val_q;
        fst_idx_d      = fst_idx_q;
        fst_val_d      = fst_val_q;
        exp_found_d    = exp_found_q;
        exp_idx_d      = exp_idx_q;
        exp_val_d      = exp_val_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d       = ST_SCAN;
                    req_ready_d   = 1'b0;
                    legal_d       = bus.req_legal;
                    explore_hit_d = bus.req_explore && (lfsr[7:0] < bus.epsilon);
                    start_d       = IDX_WIDTH'(lfsr[15:8] % 8'(N_ACTIONS));
                    q_rd_state_d  = bus.req_state;
                    q_rd_action_d = '0;
                    q_rd_en_d     = bus.req_legal[0];
                    issuing_d     = 1'b1;
                    eval_valid_d  = 1'b0;
                    best_found_d  = 1'b0;
                    exp_found_d   = 1'b0;
                end
            end

            ST_SCAN: begin
                // column issued this cycle is evaluated when its data returns
                eval_valid_d = issuing_q;
                eval_legal_d = q_rd_en_q;
                eval_idx_d   = q_rd_action_q;

                if (issuing_q) begin
                    if (q_rd_action_q == LAST_IDX) begin
                        issuing_d     = 1'b0;
                        q_rd_en_d     = 1'b0;
                        q_rd_action_d = '0;
                    end else begin
                        q_rd_action_d = next_idx;
                        q_rd_en_d     = legal_q[next_idx];
                    end
                end

                if (eval_valid_q && eval_legal_q) begin
                    if (!best_found_q || ($signed(bus.q_rd_data) > $signed(best_val_q))) begin
                        best_idx_d = eval_idx_q;
                        best_val_d = bus.q_rd_data;
                    end
                    if (!best_found_q) begin
                        fst_idx_d = eval_idx_q;
                        fst_val_d = bus.q_rd_data;
                    end
                    best_found_d = 1'b1;
                    if (!exp_found_q && (eval_idx_q >= start_q)) begin
                        exp_found_d = 1'b1;
                        exp_idx_d   = eval_idx_q;
                        exp_val_d   = bus.q_rd_data;
                    end
                end

                if (eval_valid_q && (eval_idx_q == LAST_IDX)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    if (!best_found_d) begin
                        rsp_none_d     = 1'b1;
                        rsp_explored_d = 1'b0;
                        rsp_action_d   = '0;
                        rsp_q_d        = '0;
                    end else if (explore_hit_q) begin
                        rsp_none_d     = 1'b0;
                        rsp_explored_d = 1'b1;
                        rsp_action_d   = exp_found_d ? exp_idx_d : fst_idx_d;
                        rsp_q_d        = exp_found_d ? exp_val_d : fst_val_d;
                    end else begin
                        rsp_none_d     = 1'b0;
                        rsp_explored_d = 1'b0;
                        rsp_action_d   = best_idx_d;
                        rsp_q_d        = best_val_d;
                    end
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_action_q   <= '0;
            rsp_q_q        <= '0;
            rsp_none_q     <= 1'b0;
            rsp_explored_q <= 1'b0;
            q_rd_en_q      <= 1'b0;
            q_rd_state_q   <= '0;
            q_rd_action_q  <= '0;
            legal_q        <= '0;
            explore_hit_q  <= 1'b0;
            start_q        <= '0;
            issuing_q      <= 1'b0;
            eval_valid_q   <= 1'b0;
            eval_legal_q   <= 1'b0;
            eval_idx_q     <= '0;
            best_found_q   <= 1'b0;
            best_idx_q     <= '0;
            best_val_q     <= '0;
            fst_idx_q      <= '0;
            fst_val_q      <= '0;
            exp_found_q    <= 1'b0;
            exp_idx_q      <= '0;
            exp_val_q      <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_action_q   <= rsp_action_d;
            rsp_q_q        <= rsp_q_d;
            rsp_none_q     <= rsp_none_d;
            rsp_explored_q <= rsp_explored_d;
            q_rd_en_q      <= q_rd_en_d;
            q_rd_state_q   <= q_rd_state_d;
            q_rd_action_q  <= q_rd_action_d;
            legal_q        <= legal_d;
            explore_hit_q  <= explore_hit_d;
            start_q        <= start_d;
            issuing_q      <= issuing_d;
            eval_valid_q   <= eval_valid_d;
            eval_legal_q   <= eval_legal_d;
            eval_idx_q     <= eval_idx_d;
            best_found_q   <= best_found_d;
            best_idx_q     <= best_idx_d;
            best_val_q     <= best_val_d;
            fst_idx_q      <= fst_idx_d;
            fst_val_q      <= fst_val_d;
            exp_found_q    <= exp_found_d;
            exp_idx_q      <= exp_idx_d;
            exp_val_q      <= exp_val_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_action   = rsp_action_q;
    assign bus.rsp_q        = rsp_q_q;
    assign bus.rsp_none     = rsp_none_q;
    assign bus.rsp_explored = rsp_explored_q;
    assign bus.q_rd_en      = q_rd_en_q;
    assign bus.q_rd_state   = q_rd_state_q;
    assign bus.q_rd_action  = q_rd_action_q;
endmodule

// File: tb/tb_policy_sel.sv
// Directed self-checking bench for policy_sel.
module tb_policy_sel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  mem [9];
    logic [15:0] lfsr_m;

    policy_sel_if bus ();

    policy_sel dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Q-table row: one-cycle read latency; idle reads return a poison value
    always @(posedge clk) begin
        if (bus.q_rd_en) bus.q_rd_data <= mem[bus.q_rd_action];
        else             bus.q_rd_data <= 8'h7F;
    end

    // reference LFSR: x^16+x^14+x^13+x^11+1, Galois, seed ACE1
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // drive one request from the phase just after a clock edge; returns cycles to rsp_valid
    task automatic run_req(input logic [17:0] st, input logic [8:0] lg, input logic ex,
                           input logic [7:0] eps, output int lat, output logic [8:0] en_bits,
                           output logic act_ok, output logic [17:0] st_seen);
        int n;
        bus.req_valid   = 1'b1;
        bus.req_state   = st;
        bus.req_legal   = lg;
        bus.req_explore = ex;
        bus.epsilon     = eps;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n       = 1;
        en_bits = '0;
        act_ok  = 1'b1;
        st_seen = '0;
        while (!bus.rsp_valid && n < 40) begin
            if (n <= 9) begin
                en_bits[n-1] = bus.q_rd_en;
                if (bus.q_rd_action !== 4'(n - 1)) act_ok = 1'b0;
            end
            if (n == 1) st_seen = bus.q_rd_state;
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got = {bus.rsp_none, bus.rsp_explored, bus.rsp_action, bus.rsp_q};
        total++;
        if (got !== 14'h0) begin bad++; $display("FAIL reset_rsp: got %h exp 0000", got); end
        total++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL reset_hs: got %b exp 10", {bus.req_ready, bus.rsp_valid});
        end
        total++;
        if ({bus.q_rd_en, bus.q_rd_action, bus.q_rd_state} !== 23'h0) begin
            bad++; $display("FAIL reset_rd: got %h exp 0", {bus.q_rd_en, bus.q_rd_action, bus.q_rd_state});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_greedy_tie();
        int lat; logic [8:0] en; logic ok; logic [17:0] ss;
        logic [7:0] row [9] = '{8'd3, 8'd7, 8'hFE, 8'd7, 8'd0, 8'd1, 8'd5, 8'd6, 8'd4};
        mem = row;
        run_req(18'h2A5C3, 9'h1FF, 1'b0, 8'd200, lat, en, ok, ss);
        total++;
        if (lat !== 11) begin bad++; $display("FAIL tie_latency: got %0d exp 11", lat); end
        total++;
        if ({bus.rsp_none, bus.rsp_explored, bus.rsp_action, bus.rsp_q} !== {2'b00, 4'd1, 8'd7}) begin
            bad++; $display("FAIL tie_result: got act=%0d q=%0d exp act=1 q=7", bus.rsp_action, $signed(bus.rsp_q));
        end
        total++;
        if (ss !== 18'h2A5C3) begin bad++; $display("FAIL tie_rd_state: got %h exp 2a5c3", ss); end
        handshake();
    endtask

    task automatic test_masked();
        int lat; logic [8:0] en; logic ok; logic [17:0] ss;
        for (int i = 0; i < 9; i++) mem[i] = 8'd100;
        mem[2] = 8'(-5);
        mem[4] = 8'(-9);
        run_req(18'h00011, 9'b000010100, 1'b0, 8'd0, lat, en, ok, ss);
        total++;
        if ({bus.rsp_action, bus.rsp_q} !== {4'd2, 8'(-5)}) begin
            bad++; $display("FAIL mask_result: got act=%0d q=%0d exp act=2 q=-5", bus.rsp_action, $signed(bus.rsp_q));
        end
        total++;
        if (en !== 9'b000010100) begin bad++; $display("FAIL mask_rd_en: got %b exp 000010100", en); end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL mask_rd_order: got %b exp 1", ok); end
        handshake();
    endtask

    task automatic test_none();
        int lat; logic [8:0] en; logic ok; logic [17:0] ss;
        for (int i = 0; i < 9; i++) mem[i] = 8'(i + 10);
        run_req(18'h3FFFF, 9'h000, 1'b1, 8'd255, lat, en, ok, ss);
        total++;
        if (lat !== 11) begin bad++; $display("FAIL none_latency: got %0d exp 11", lat); end
        total++;
        if ({bus.rsp_none, bus.rsp_explored, bus.rsp_action, bus.rsp_q} !== {2'b10, 4'd0, 8'd0}) begin
            bad++; $display("FAIL none_result: got none=%b expl=%b act=%0d q=%0d exp 1 0 0 0",
                            bus.rsp_none, bus.rsp_explored, bus.rsp_action, $signed(bus.rsp_q));
        end
        total++;
        if (en !== 9'h000) begin bad++; $display("FAIL none_rd_en: got %b exp 000000000", en); end
        handshake();
    endtask

    task automatic test_explore();
        int lat; logic [8:0] en; logic ok; logic [17:0] ss;
        logic [7:0] tgt_start [2] = '{8'd7, 8'd2};
        logic [3:0] exp_act   [2] = '{4'd1, 4'd3};
        for (int c = 0; c < 2; c++) begin
            int w = 0;
            for (int i = 0; i < 9; i++) mem[i] = 8'd90;
            mem[1] = (c == 0) ? 8'(-20) : 8'd50;
            mem[3] = (c == 0) ? 8'd50 : 8'(-20);
            while (!(((lfsr_m[15:8] % 8'd9) == tgt_start[c]) && (lfsr_m[7:0] != 8'hFF)) && w < 2000) begin
                @(posedge clk); #1;
                w++;
            end
            total++;
            if (w >= 2000) begin bad++; $display("FAIL explore_wait: got %0d cycles exp <2000", w); end
            run_req(18'h00100, 9'b000001010, 1'b1, 8'd255, lat, en, ok, ss);
            total++;
            if ({bus.rsp_explored, bus.rsp_action, bus.rsp_q} !== {1'b1, exp_act[c], 8'(-20)}) begin
                bad++; $display("FAIL explore_pick%0d: got expl=%b act=%0d q=%0d exp 1 %0d -20",
                                c, bus.rsp_explored, bus.rsp_action, $signed(bus.rsp_q), exp_act[c]);
            end
            handshake();
        end
    endtask

    task automatic test_eps0_single();
        int lat; logic [8:0] en; logic ok; logic [17:0] ss;
        logic hit;
        for (int i = 0; i < 9; i++) mem[i] = 8'd0;
        mem[1] = 8'd50;
        mem[3] = 8'(-20);
        run_req(18'h00200, 9'b000001010, 1'b1, 8'd0, lat, en, ok, ss);
        total++;
        if ({bus.rsp_explored, bus.rsp_action, bus.rsp_q} !== {1'b0, 4'd1, 8'd50}) begin
            bad++; $display("FAIL eps0_greedy: got expl=%b act=%0d q=%0d exp 0 1 50",
                            bus.rsp_explored, bus.rsp_action, $signed(bus.rsp_q));
        end
        handshake();
        mem[6] = 8'h80;
        run_req(18'h00300, 9'b001000000, 1'b0, 8'd255, lat, en, ok, ss);
        total++;
        if ({bus.rsp_none, bus.rsp_explored, bus.rsp_action, bus.rsp_q} !== {2'b00, 4'd6, 8'h80}) begin
            bad++; $display("FAIL single_neg_greedy: got act=%0d q=%0d exp act=6 q=-128",
                            bus.rsp_action, $signed(bus.rsp_q));
        end
        handshake();
        hit = (lfsr_m[7:0] < 8'd255);
        run_req(18'h00300, 9'b001000000, 1'b1, 8'd255, lat, en, ok, ss);
        total++;
        if ({bus.rsp_explored, bus.rsp_action, bus.rsp_q} !== {hit, 4'd6, 8'h80}) begin
            bad++; $display("FAIL single_neg_explore: got expl=%b act=%0d q=%0d exp %b 6 -128",
                            bus.rsp_explored, bus.rsp_action, $signed(bus.rsp_q), hit);
        end
        handshake();
    endtask

    task automatic test_hold();
        int lat; logic [8:0] en; logic ok; logic [17:0] ss;
        logic [7:0] row [9] = '{8'd3, 8'd7, 8'hFE, 8'd7, 8'd0, 8'd1, 8'd5, 8'd6, 8'd4};
        mem = row;
        run_req(18'h00400, 9'b111000000, 1'b0, 8'd0, lat, en, ok, ss);
        bus.req_valid   = 1'b1;
        bus.req_state   = 18'h00500;
        bus.req_legal   = 9'b000000101;
        bus.req_explore = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_action, bus.rsp_q} !== {2'b10, 4'd7, 8'd6}) begin
                bad++; $display("FAIL hold_cycle%0d: got v=%b rdy=%b act=%0d q=%0d exp 1 0 7 6",
                                i, bus.rsp_valid, bus.req_ready, bus.rsp_action, $signed(bus.rsp_q));
            end
            @(posedge clk); #1;
        end
        handshake();
        total++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            bad++; $display("FAIL hold_release: got v=%b rdy=%b exp 0 1", bus.rsp_valid, bus.req_ready);
        end
        run_req(18'h00500, 9'b000000101, 1'b0, 8'd0, lat, en, ok, ss);
        total++;
        if ({lat[3:0], bus.rsp_action, bus.rsp_q} !== {4'd11, 4'd0, 8'd3}) begin
            bad++; $display("FAIL hold_next_req: got lat=%0d act=%0d q=%0d exp 11 0 3",
                            lat, bus.rsp_action, $signed(bus.rsp_q));
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat; logic [8:0] en; logic ok; logic [17:0] ss;
        logic [7:0] row [9] = '{8'd3, 8'd7, 8'hFE, 8'd7, 8'd0, 8'd1, 8'd5, 8'd6, 8'd4};
        mem = row;
        bus.req_valid   = 1'b1;
        bus.req_state   = 18'h12345;
        bus.req_legal   = 9'h1FF;
        bus.req_explore = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.q_rd_en, bus.q_rd_action, bus.q_rd_state} !== {3'b100, 4'd0, 18'd0}) begin
            bad++; $display("FAIL midreset_outputs: got rdy=%b v=%b en=%b act=%0d st=%h exp 1 0 0 0 0",
                            bus.req_ready, bus.rsp_valid, bus.q_rd_en, bus.q_rd_action, bus.q_rd_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_req(18'h12345, 9'b111110000, 1'b0, 8'd0, lat, en, ok, ss);
        total++;
        if ({lat[3:0], bus.rsp_none, bus.rsp_action, bus.rsp_q} !== {4'd11, 1'b0, 4'd7, 8'd6}) begin
            bad++; $display("FAIL midreset_next: got lat=%0d act=%0d q=%0d exp 11 7 6",
                            lat, bus.rsp_action, $signed(bus.rsp_q));
        end
        handshake();
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_state   = '0;
        bus.req_legal   = '0;
        bus.req_explore = 1'b0;
        bus.epsilon     = '0;
        bus.rsp_ready   = 1'b0;
        for (int i = 0; i < 9; i++) mem[i] = '0;
        test_reset();
        test_greedy_tie();
        test_masked();
        test_none();
        test_explore();
        test_eps0_single();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/policy_sel.md
Name: policy_sel

Overview:
- Parametrised, sequential successor to the combinational argmax policy block.
- On each request it scans one Q-table row through a synchronous read port, one action per cycle.
- Illegal actions (occupied squares) are masked out of the scan.
- Returns either the greedy (max-Q) legal action or, under an epsilon-greedy draw, a pseudo-random legal action.
- Sits between the game controller (request/response) and the Q-table RAM (read port).

Parameters:
- Q_WIDTH, 8: Q-value width, signed two's complement.
- N_ACTIONS, 9: actions per state (board squares).
- IDX_WIDTH, 4: action index width; must satisfy 2^IDX_WIDTH >= N_ACTIONS.
- STATE_WIDTH, 18: encoded board-state width (Q-table row address).
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_state  in  STATE_WIDTH  row to scan
- req_legal  in  N_ACTIONS  bit k=1 means action k is legal
- req_explore  in  1  enable epsilon-greedy for this request
- epsilon  in  8  exploration threshold, sampled at accept
- q_rd_en  out  1  Q-table read strobe
- q_rd_state  out  STATE_WIDTH  read row
- q_rd_action  out  IDX_WIDTH  read column
- q_rd_data  in  Q_WIDTH  read data, valid exactly 1 cycle after q_rd_en
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_action  out  IDX_WIDTH  chosen action
- rsp_q  out  Q_WIDTH  Q of chosen action
- rsp_none  out  1  no legal action existed
- rsp_explored  out  1  result came from exploration

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_action=0; rsp_q=0; rsp_none=0; rsp_explored=0; q_rd_en=0; q_rd_state=0; q_rd_action=0; LFSR=LFSR_SEED.
- Reset asserted mid-scan or mid-response aborts everything back to these values. The pending response is lost and the LFSR is reseeded.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle while out of reset.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&&req_ready at cycle T.
  - Latch req_state, req_legal, req_explore and epsilon.
  - Latch explore_hit = req_explore && (lfsr[7:0] < epsilon).
  - Latch start = lfsr[15:8] mod N_ACTIONS.
  - Go to SCAN.
- SCAN:
  - Cycles T+1..T+N_ACTIONS issue column k=0..N_ACTIONS-1 in order.
  - q_rd_state is the latched state; q_rd_action=k; q_rd_en=legal[k]. Illegal slots still take one cycle, so latency is fixed.
  - Data for k is evaluated at cycle T+k+2, and only if legal[k].
  - Greedy tracker: keep best_q/best_idx using signed compare. Replace only on strictly greater, so ties resolve to the lowest index. The first legal entry always loads.
  - Explore tracker: record the first legal index >= start (and its Q). Separately record the first legal index overall, used as the wrap-around fallback.
  - After the last evaluation, go to RESP.
- RESP:
  - rsp_valid=1 from cycle T+N_ACTIONS+2; req_ready=0.
  - Fixed latency from accept to rsp_valid is N_ACTIONS+2 cycles (11 with defaults).
  - If no legal action: rsp_none=1, rsp_action=0, rsp_q=0, rsp_explored=0.
  - Else if explore_hit: rsp_action is the wrap-around pick, with its Q; rsp_explored=1.
  - Else: greedy result, rsp_explored=0.
  - Outputs hold stable until rsp_valid&&rsp_ready. Then return to IDLE; rsp_valid drops the next cycle.
  - A new request is accepted no earlier than the cycle after the handshake.
- Boundaries:
  - epsilon=0: never explores.
  - epsilon=255: explores unless lfsr[7:0]==255.
  - req_explore=0: ignores epsilon.
  - Exactly one legal action: greedy and explore give the same index.
  - Most-negative Q (-128) is a valid maximum when it is the only legal entry.

Decomposition:
- policy_pkg holds:
  - Q_WIDTH, N_ACTIONS, IDX_WIDTH and STATE_WIDTH defaults.
  - LFSR_SEED and the tap mask.
  - The FSM state enum (IDLE/SCAN/RESP).
- One sub-module: lfsr16, a free-running Galois LFSR with seed parameter and async reset.

Test Plan:
- Legal all 1s, row Q = {3,7,-2,7,0,1,5,6,4}, req_explore=0 -> rsp_action=1, rsp_q=7 (lowest-index tie), rsp_valid exactly 11 cycles after accept.
- Legal=9'b000010100 (actions 2 and 4), Q[2]=-5, Q[4]=-9, all others 100 -> rsp_action=2, rsp_q=-5; q_rd_en high only in the cycles issuing columns 2 and 4.
- Legal all 0s -> rsp_none=1, rsp_action=0, rsp_q=0, latency still 11.
- req_explore=1, epsilon=255, LFSR forced so start=7, legal only {1,3} -> wrap-around pick rsp_action=1, rsp_explored=1.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; a new req_valid is not accepted until after the handshake.
- Assert rst at scan cycle 4 -> all outputs go to reset values immediately; the next request completes normally with the correct greedy result.
